// File: rtl/prng_lcg_ctrl_pkg.sv
// Shared types and constants for the LCG PRNG sequencer: FSM state encoding,
// default width and LCG coefficients, and the multiplier latency helper.
package prng_pkg;

    localparam int          PRNG_WIDTH = 32;
    localparam logic [31:0] LCG_A      = 32'd1664525;
    localparam logic [31:0] LCG_C      = 32'd1013904223;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        UPDATE,
        HOLD
    } prng_state_t;

    // Operand-sampling edge plus the multiplier's output register stages.
    function automatic int mult_lat(input int depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/prng_lcg_ctrl.sv
// LCG sequencer: x' = A*x + C mod 2^WIDTH using an external pipelined multiplier,
// new words presented on a valid/ready stream. Define PRNG_TEMPER_EN to xor-shift temper rand_data.
module prng_lcg_ctrl
    import prng_pkg::*;
#(
    parameter int                WIDTH      = PRNG_WIDTH,
    parameter int                MULT_DEPTH = 5,
    parameter logic [WIDTH-1:0]  A_CONST    = WIDTH'(LCG_A),
    parameter logic [WIDTH-1:0]  C_CONST    = WIDTH'(LCG_C)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed_value,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic [2*WIDTH-1:0]   mult_product,
    output logic [WIDTH-1:0]     rand_data,
    output logic                 rand_valid,
    input  logic                 rand_ready,
    output logic                 busy
);

    localparam int               MULT_LAT = mult_lat(MULT_DEPTH);
    localparam int               CNT_W    = $clog2(MULT_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LAT - 1);

    prng_state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] x, x_d;
    logic [WIDTH-1:0] data_d;
    logic             valid_d;
    logic [WIDTH-1:0] next_v;
    logic [WIDTH-1:0] tempered;
    logic             unused_hi;

    assign mult_b    = A_CONST;
    assign next_v    = mult_product[WIDTH-1:0] + C_CONST;
    assign unused_hi = ^mult_product[2*WIDTH-1:WIDTH];
    assign busy      = (state == ISSUE) || (state == WAIT) || (state == UPDATE);

`ifdef PRNG_TEMPER_EN
    assign tempered = next_v ^ (next_v >> (WIDTH/2));
`else
    assign tempered = next_v;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            x          <= '0;
            mult_a     <= '0;
            rand_data  <= '0;
            rand_valid <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            x          <= x_d;
            // Tracks x's next value so the operand already equals x while in ISSUE.
            mult_a     <= x_d;
            rand_data  <= data_d;
            rand_valid <= valid_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        x_d     = x;
        data_d  = rand_data;
        valid_d = rand_valid;
        if (seed_load) begin
            // Restarting the counter re-aligns capture with the new operand, so
            // products still in flight from earlier issues are never taken.
            x_d     = seed_value;
            valid_d = 1'b0;
            cnt_d   = CNT_LOAD;
            state_d = ISSUE;
        end else begin
            case (state)
                IDLE: ;
                ISSUE: begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = UPDATE;
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                UPDATE: begin
                    x_d     = next_v;
                    data_d  = tempered;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (rand_ready) begin
                        valid_d = 1'b0;
                        state_d = ISSUE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
